// File: rtl/mem_pkg.sv
// Shared defaults, sticky-error bit positions and region select for the banked main memory.
package mem_pkg;
   localparam int          DEF_DATA_W     = 32;
   localparam int          DEF_SYS_WORDS  = 16;
   localparam int          DEF_USER_BASE  = 2048;
   localparam int          DEF_USER_WORDS = 128;
   localparam logic [31:0] DEF_BOOT_WORD  = 32'h81C0_2800;

   localparam int ERR_ALIGN = 0;
   localparam int ERR_RANGE = 1;
   localparam int ERR_PROT  = 2;

   typedef enum logic [1:0] {REG_SYS, REG_USER, REG_NONE} region_e;
endpackage

// File: rtl/mem_addr_decode.sv
// Combinational byte-address decode into region, word index and align/range faults.
// Zero latency; no flow control.
module mem_addr_decode
   import mem_pkg::*;
#(
   parameter int SYS_WORDS  = DEF_SYS_WORDS,
   parameter int USER_BASE  = DEF_USER_BASE,
   parameter int USER_WORDS = DEF_USER_WORDS
) (
   input  logic [31:0] address,
   output region_e     region,
   output logic [29:0] word_idx,
   output logic        align_flt,
   output logic        range_flt
);
   // Bounds are compared at 33 bits so a user region ending at 4 GiB does not wrap.
   localparam logic [32:0] SYS_END = 33'(longint'(SYS_WORDS) * 4);
   localparam logic [32:0] USER_LO = 33'(longint'(USER_BASE));
   localparam logic [32:0] USER_HI = 33'(longint'(USER_BASE) + longint'(USER_WORDS) * 4);

   logic [32:0] addr_x;
   logic [31:0] user_off;

   assign addr_x   = {1'b0, address};
   assign user_off = address - USER_LO[31:0];

   always_comb begin
      region   = REG_NONE;
      word_idx = '0;
      if (addr_x < SYS_END) begin
         region   = REG_SYS;
         word_idx = address[31:2];
      end else if (addr_x >= USER_LO && addr_x < USER_HI) begin
         region   = REG_USER;
         word_idx = user_off[31:2];
      end
   end

   assign align_flt = |address[1:0];
   assign range_flt = (region == REG_NONE);
endmodule

// File: rtl/main_memory_banked.sv
// Two-region word memory (boot-protected system bank + user bank) with byte-enable writes.
// Read data and error flags one cycle after the request; always accepts, no backpressure.
module main_memory_banked
   import mem_pkg::*;
#(
   parameter int                DATA_W     = DEF_DATA_W,
   parameter int                SYS_WORDS  = DEF_SYS_WORDS,
   parameter int                USER_BASE  = DEF_USER_BASE,
   parameter int                USER_WORDS = DEF_USER_WORDS,
   parameter logic [DATA_W-1:0] BOOT_WORD  = DATA_W'(DEF_BOOT_WORD)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         address,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [DATA_W/8-1:0] be,
   input  logic                rd,
   input  logic                wr,
   input  logic                sys_wp,
   input  logic                err_clr,
   output logic [DATA_W-1:0]   data_out,
   output logic                rd_valid,
   output logic                err,
   output logic [2:0]          err_status
);
   localparam int NB      = DATA_W / 8;
   localparam int SYS_AW  = (SYS_WORDS > 1) ? $clog2(SYS_WORDS) : 1;
   localparam int USER_AW = (USER_WORDS > 1) ? $clog2(USER_WORDS) : 1;

   logic [DATA_W-1:0] sys_mem  [SYS_WORDS];
   logic [DATA_W-1:0] user_mem [USER_WORDS];

   region_e             region;
   logic [29:0]         word_idx;
   logic                align_flt, range_flt;
   logic [SYS_AW-1:0]   sys_idx;
   logic [USER_AW-1:0]  user_idx;
   logic                unused_idx;
   logic                acc, addr_ok, is_sys, is_user;
   logic                sys_we, user_we;
   logic [2:0]          flt;
   logic [DATA_W-1:0]   rd_word;

   mem_addr_decode #(
      .SYS_WORDS  (SYS_WORDS),
      .USER_BASE  (USER_BASE),
      .USER_WORDS (USER_WORDS)
   ) u_decode (
      .address   (address),
      .region    (region),
      .word_idx  (word_idx),
      .align_flt (align_flt),
      .range_flt (range_flt)
   );

   assign sys_idx    = word_idx[SYS_AW-1:0];
   assign user_idx   = word_idx[USER_AW-1:0];
   assign unused_idx = ^word_idx;

   assign acc     = rd | wr;
   assign addr_ok = !align_flt && !range_flt;
   assign is_sys  = (region == REG_SYS);
   assign is_user = (region == REG_USER);

   assign flt[ERR_ALIGN] = acc && align_flt;
   assign flt[ERR_RANGE] = acc && range_flt;
   assign flt[ERR_PROT]  = wr && sys_wp && is_sys;

   // Word 0 holds the boot vector: writes to it are dropped without raising an error.
   assign sys_we  = rst_n && wr && addr_ok && is_sys && !sys_wp && (sys_idx != '0);
   assign user_we = rst_n && wr && addr_ok && is_user;

   always_comb begin
      rd_word = '0;
      if (addr_ok && is_sys)
         rd_word = (sys_idx == '0) ? BOOT_WORD : sys_mem[sys_idx];
      else if (addr_ok && is_user)
         rd_word = user_mem[user_idx];
   end

   // Arrays carry no reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (sys_we && be[i])
            sys_mem[sys_idx][8*i +: 8] <= data_in[8*i +: 8];
         if (user_we && be[i])
            user_mem[user_idx][8*i +: 8] <= data_in[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         rd_valid   <= 1'b0;
         err        <= 1'b0;
         err_status <= '0;
      end else begin
         rd_valid <= rd;
         if (rd)
            data_out <= rd_word;
         err        <= |flt;
         err_status <= (err_clr ? 3'b000 : err_status) | flt;
      end
   end
endmodule

// File: tb/tb_main_memory_banked.sv
// Directed and randomized checks of main_memory_banked against a word-array reference model.
module tb_main_memory_banked;
   localparam logic [31:0] BOOT = 32'h81C0_2800;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [3:0]  be;
   logic        rd, wr, sys_wp, err_clr;
   logic [31:0] data_out;
   logic        rd_valid, err;
   logic [2:0]  err_status;

   int checks   = 0;
   int failures = 0;

   logic [31:0] sys_m  [16];
   logic [31:0] user_m [128];
   logic [31:0] last_dout;
   logic [2:0]  status_m;

   main_memory_banked dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .address    (address),
      .data_in    (data_in),
      .be         (be),
      .rd         (rd),
      .wr         (wr),
      .sys_wp     (sys_wp),
      .err_clr    (err_clr),
      .data_out   (data_out),
      .rd_valid   (rd_valid),
      .err        (err),
      .err_status (err_status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access cycle: drive, clock, then compare against the model's view of the spec rules.
   task automatic op(input string tag, input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] d, input logic [3:0] b, input logic p, input logic c);
      logic        al, insys, inuser, rng, prot, acc;
      logic [31:0] exp_rd, word;
      al     = (a % 4) != 0;
      insys  = a < 64;
      inuser = (a >= 2048) && (a < 2048 + 512);
      rng    = !insys && !inuser;
      acc    = r || w;
      prot   = w && p && insys;
      exp_rd = 32'h0;
      if (!al && insys)
         exp_rd = (a == 0) ? BOOT : sys_m[a / 4];
      else if (!al && inuser)
         exp_rd = user_m[(a - 2048) / 4];

      address = a; rd = r; wr = w; data_in = d; be = b; sys_wp = p; err_clr = c;
      @(posedge clk);
      #1;
      rd = 1'b0; wr = 1'b0; err_clr = 1'b0;

      if (r) last_dout = exp_rd;
      status_m = (c ? 3'b000 : status_m) | {prot, acc && rng, acc && al};
      chk({tag, ".rd_valid"}, {31'h0, rd_valid}, {31'h0, r});
      chk({tag, ".data_out"}, data_out, last_dout);
      chk({tag, ".err"}, {31'h0, err}, {31'h0, (acc && (al || rng)) || prot});
      chk({tag, ".err_status"}, {29'h0, err_status}, {29'h0, status_m});

      if (w && !al && !rng && !(insys && (p || a == 0))) begin
         word = insys ? sys_m[a / 4] : user_m[(a - 2048) / 4];
         for (int i = 0; i < 4; i++)
            if (b[i]) word[8*i +: 8] = d[8*i +: 8];
         if (insys) sys_m[a / 4] = word;
         else       user_m[(a - 2048) / 4] = word;
      end
   endtask

   task automatic idle(input string tag);
      op(tag, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] a, d;
      int          sel;

      rst_n = 1'b0; address = '0; data_in = '0; be = '0;
      rd = 1'b0; wr = 1'b0; sys_wp = 1'b0; err_clr = 1'b0;
      last_dout = '0; status_m = '0;
      #12;
      chk("reset.data_out", data_out, 32'h0);
      chk("reset.rd_valid", {31'h0, rd_valid}, 32'h0);
      chk("reset.err", {31'h0, err}, 32'h0);
      chk("reset.err_status", {29'h0, err_status}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Fill both banks with known data (word 0 write is silently dropped).
      for (int i = 0; i < 16; i++)
         op("init_sys", i * 4, 1'b0, 1'b1, $urandom, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 128; i++)
         op("init_user", 2048 + i * 4, 1'b0, 1'b1, $urandom, 4'hF, 1'b0, 1'b0);
      op("boot_rd", 0, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);

      op("wr2048", 2048, 1'b0, 1'b1, 32'h1, 4'hF, 1'b0, 1'b0);
      op("rd2048", 2048, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      chk("rd2048.const", data_out, 32'h0000_0001);

      op("wr2052_zero", 2052, 1'b0, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0);
      op("wr2052_be", 2052, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0);
      op("wr2052_be0", 2052, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0);
      op("rd2052", 2052, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      chk("rd2052.const", data_out, 32'h00BB_00DD);

      op("rd2049", 2049, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      chk("rd2049.status", {29'h0, err_status}, 32'h1);
      idle("err_pulse_end");
      op("clr", 0, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b1);
      chk("clr.status", {29'h0, err_status}, 32'h0);

      op("wp_wr4", 4, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
      chk("wp_wr4.status", {29'h0, err_status}, 32'h4);
      op("wp_rd4", 4, 1'b1, 1'b0, 0, 4'h0, 1'b1, 1'b0);
      op("clr_wr4", 4, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
      op("rd4", 4, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      chk("rd4.const", data_out, 32'h1234_5678);

      op("wr2088", 2088, 1'b0, 1'b1, 32'h5, 4'hF, 1'b0, 1'b0);
      op("rdwr2088", 2088, 1'b1, 1'b1, 32'h8, 4'hF, 1'b0, 1'b0);
      chk("rdwr2088.const", data_out, 32'h5);
      op("rd2088", 2088, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      chk("rd2088.const", data_out, 32'h8);

      op("oor_rd", 32'hFFFF_FFFC, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      op("set_and_clr", 5000, 1'b0, 1'b1, 32'h9, 4'hF, 1'b0, 1'b1);

      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       a = $urandom_range(0, 15) * 4;
            1:       a = 2048 + $urandom_range(0, 127) * 4;
            2:       a = ($urandom_range(0, 1) ? 2048 : 0) + $urandom_range(0, 127) * 4 + $urandom_range(1, 3);
            default: a = $urandom_range(0, 1) ? $urandom_range(64, 2047) : $urandom_range(2560, 1000000);
         endcase
         d = $urandom;
         op("rand", a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
            4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end

      // Reset lands while a read is outstanding: it must not surface afterwards.
      address = 2048; rd = 1'b1; wr = 1'b0;
      #3 rst_n = 1'b0;
      rd = 1'b0;
      #1;
      chk("midrst.data_out", data_out, 32'h0);
      chk("midrst.rd_valid", {31'h0, rd_valid}, 32'h0);
      chk("midrst.err_status", {29'h0, err_status}, 32'h0);
      last_dout = '0; status_m = '0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle("post_rst0");
      idle("post_rst1");
      op("post_rst_boot", 0, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      chk("post_rst_boot.const", data_out, BOOT);
      op("post_rst_keep", 2088, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);
      for (int i = 1; i < 16; i++)
         op("post_rst_sys", i * 4, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
